// File: rtl/ecc_lockstep_fault_mon.sv
// ecc_lockstep_fault_mon: lockstep SECDED fault monitor on the FIFO read path.
// Two identical SECDED decoders check every beat; any disagreement in their
// {sbit, dbit, mask} results is a lockstep fault. Beats flow through a
// single valid/ready register stage with saturating statistics and a
// sticky health FSM (NORMAL -> SUSPECT -> FAILED).
// Optional build macro ECC_FAULT_INJ_EN adds the inj_req port, which forces
// a decoder-1 mask disagreement on the next accepted beat.
//
// Code layout: Hamming positions 1..DATA_WIDTH+PARITY_WIDTH-1, check bits at
// the power-of-two positions (parity[i] at position 2^i), data bits fill the
// remaining positions in ascending order. parity[PARITY_WIDTH-1] is the
// overall parity of all data and Hamming check bits.

module ecc_106_cal #(
   parameter int DATA_WIDTH   = 106,
   parameter int PARITY_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [PARITY_WIDTH-1:0] i_parity,
   input  logic                    i_bypass,
   output logic                    o_sbit,
   output logic                    o_dbit,
   output logic [DATA_WIDTH-1:0]   o_mask
);

   localparam int CHK_W = PARITY_WIDTH - 1;
   localparam int N_POS = DATA_WIDTH + CHK_W;

   // Codeword position of data bit j (skips the power-of-two check positions).
   function automatic int pos_of(input int j);
      int r;
      int c;
      r = 0;
      c = 0;
      for (int q = 1; q <= N_POS; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (c == j) r = q;
            c++;
         end
      end
      return r;
   endfunction

   logic [CHK_W-1:0]      w_pos [DATA_WIDTH];
   logic [CHK_W-1:0]      w_syn;
   logic                  w_ovr;
   logic [DATA_WIDTH-1:0] w_flip;

   for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_pos
      localparam logic [CHK_W-1:0] P = CHK_W'(pos_of(j));
      assign w_pos[j] = P;
   end

   // Syndrome, overall parity and the single-bit correction mask.
   always_comb begin
      w_syn  = i_parity[CHK_W-1:0];
      w_ovr  = (^i_data) ^ (^i_parity);
      w_flip = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         for (int i = 0; i < CHK_W; i++) begin
            if (w_pos[j][i]) w_syn[i] = w_syn[i] ^ i_data[j];
         end
      end
      for (int j = 0; j < DATA_WIDTH; j++) begin
         w_flip[j] = w_ovr && (w_syn == w_pos[j]);
      end
   end

   assign o_sbit = w_ovr;
   assign o_dbit = ~w_ovr & (w_syn != '0);
   assign o_mask = i_bypass ? '0 : w_flip;

endmodule

module ecc_lockstep_fault_mon #(
   parameter int DATA_WIDTH   = 106,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 8,
   parameter int FAULT_THRESH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ecc_fault_detc_en,
   input  logic                    bypass,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    sbit_err,
   output logic                    dbit_err,
   output logic                    ecc_fault,
   output logic                    fail_flag,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   input  logic                    clr_cnt,
   input  logic                    fail_clr
`ifdef ECC_FAULT_INJ_EN
   ,
   input  logic                    inj_req
`endif
);

   localparam logic [1:0] ST_NORMAL  = 2'd0;
   localparam logic [1:0] ST_SUSPECT = 2'd1;
   localparam logic [1:0] ST_FAILED  = 2'd2;
   localparam logic [7:0] THRESH8    = 8'(FAULT_THRESH);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   logic                  w_acc;
   logic                  w_in_rdy;
   logic                  w_mis;
   logic                  w_sbit0, w_dbit0, w_sbit1, w_dbit1;
   logic [DATA_WIDTH-1:0] w_mask0, w_mask1, w_mask1_c;

   logic                  r_out_vld;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_sbit, r_dbit, r_fault;
   logic [CNT_WIDTH-1:0]  r_sbit_cnt, r_dbit_cnt, r_fault_cnt;
   logic [1:0]            r_state;
   logic [7:0]            r_consec;

   ecc_106_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec0 (
      .i_data(data_in), .i_parity(parity_in), .i_bypass(bypass),
      .o_sbit(w_sbit0), .o_dbit(w_dbit0), .o_mask(w_mask0)
   );

   ecc_106_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec1 (
      .i_data(data_in), .i_parity(parity_in), .i_bypass(bypass),
      .o_sbit(w_sbit1), .o_dbit(w_dbit1), .o_mask(w_mask1)
   );

`ifdef ECC_FAULT_INJ_EN
   logic r_inj_pend;

   // Arm on inj_req; the pending request is consumed by the next accepted beat.
   always_ff @(posedge clk) begin
      if (rst) r_inj_pend <= 1'b0;
      else     r_inj_pend <= inj_req | (r_inj_pend & ~w_acc);
   end

   assign w_mask1_c = w_mask1 ^ {{(DATA_WIDTH-1){1'b0}}, r_inj_pend};
`else
   assign w_mask1_c = w_mask1;
`endif

   assign w_in_rdy = ~r_out_vld | out_rdy;
   assign w_acc    = in_vld & w_in_rdy;
   assign w_mis    = ecc_fault_detc_en &
                     ({w_sbit0, w_dbit0, w_mask0} != {w_sbit1, w_dbit1, w_mask1_c});

   // Output stage: load on accept, drain on consumer take, hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_vld  <= 1'b0;
         r_data_out <= '0;
         r_sbit     <= 1'b0;
         r_dbit     <= 1'b0;
         r_fault    <= 1'b0;
      end else if (w_acc) begin
         r_out_vld  <= 1'b1;
         r_data_out <= (w_mis || (r_state == ST_FAILED)) ? data_in : (data_in ^ w_mask0);
         r_sbit     <= w_sbit0;
         r_dbit     <= w_dbit0;
         r_fault    <= w_mis;
      end else if (out_rdy) begin
         r_out_vld  <= 1'b0;
      end
   end

   // Saturating statistics; clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         r_sbit_cnt  <= '0;
         r_dbit_cnt  <= '0;
         r_fault_cnt <= '0;
      end else if (w_acc) begin
         if (w_sbit0) r_sbit_cnt  <= sat_inc(r_sbit_cnt);
         if (w_dbit0) r_dbit_cnt  <= sat_inc(r_dbit_cnt);
         if (w_mis)   r_fault_cnt <= sat_inc(r_fault_cnt);
      end
   end

   // Lockstep health FSM: consecutive mismatching beats escalate to sticky FAILED.
   always_ff @(posedge clk) begin
      if (rst || fail_clr) begin
         r_state  <= ST_NORMAL;
         r_consec <= 8'd0;
      end else begin
         case (r_state)
            ST_NORMAL: begin
               if (w_acc && w_mis) begin
                  r_consec <= 8'd1;
                  r_state  <= (THRESH8 <= 8'd1) ? ST_FAILED : ST_SUSPECT;
               end
            end
            ST_SUSPECT: begin
               if (w_acc && w_mis) begin
                  r_consec <= r_consec + 8'd1;
                  if ((r_consec + 8'd1) >= THRESH8) r_state <= ST_FAILED;
               end else if (w_acc) begin
                  r_consec <= 8'd0;
                  r_state  <= ST_NORMAL;
               end
            end
            ST_FAILED: begin
               r_state <= ST_FAILED;
            end
            default: begin
               r_state  <= ST_NORMAL;
               r_consec <= 8'd0;
            end
         endcase
      end
   end

   assign in_rdy    = w_in_rdy;
   assign out_vld   = r_out_vld;
   assign data_out  = r_data_out;
   assign sbit_err  = r_sbit;
   assign dbit_err  = r_dbit;
   assign ecc_fault = r_fault;
   assign fail_flag = (r_state == ST_FAILED);
   assign sbit_cnt  = r_sbit_cnt;
   assign dbit_cnt  = r_dbit_cnt;
   assign fault_cnt = r_fault_cnt;

endmodule
